// File: rtl/alu_seq.sv
// alu_seq: multi-cycle RV32I/M execute unit; single-cycle ALU/branch ops plus
// iterative radix-2 multiply and restoring divide behind valid/ready handshakes.
module alu_seq #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [5:0]      alucode,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_result,
    output logic            br_taken,
    output logic            busy
);
    localparam logic [5:0] ALU_ADD = 6'd0, ALU_SUB = 6'd1, ALU_SLT = 6'd2, ALU_SLTU = 6'd3,
        ALU_XOR = 6'd4, ALU_OR = 6'd5, ALU_AND = 6'd6, ALU_SLL = 6'd7, ALU_SRL = 6'd8,
        ALU_SRA = 6'd9, ALU_LUI = 6'd10, ALU_JAL = 6'd11, ALU_JALR = 6'd12, ALU_BEQ = 6'd13,
        ALU_BNE = 6'd14, ALU_BLT = 6'd15, ALU_BGE = 6'd16, ALU_BLTU = 6'd17, ALU_BGEU = 6'd18,
        ALU_LB = 6'd19, ALU_LH = 6'd20, ALU_LW = 6'd21, ALU_LBU = 6'd22, ALU_LHU = 6'd23,
        ALU_SB = 6'd24, ALU_SH = 6'd25, ALU_SW = 6'd26,
        ALU_MUL = 6'd32, ALU_MULH = 6'd33, ALU_MULHSU = 6'd34, ALU_MULHU = 6'd35,
        ALU_DIV = 6'd36, ALU_DIVU = 6'd37, ALU_REM = 6'd38, ALU_REMU = 6'd39;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q, state_d;
    logic [SHW-1:0]    cnt_q, cnt_d;
    logic [XLEN-1:0]   res_q, res_d, hi_q, hi_d, lo_q, lo_d, b_q, b_d;
    logic [2:0]        op_q, op_d;
    logic              br_q, br_d, neg_q, neg_d, rneg_q, rneg_d;

    logic [XLEN-1:0]   s_res, spec_res, a_mag, b_mag, step_hi, step_lo, md_res;
    logic              s_br, is_md, is_div, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN:0]     mul_sum, div_r2, div_diff;
    logic [2*XLEN-1:0] prod;

    always_comb begin
        s_res = '0;
        s_br  = 1'b0;
        case (alucode)
            ALU_ADD, ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU,
            ALU_SB, ALU_SH, ALU_SW: s_res = op1 + op2;
            ALU_SUB:  s_res = op1 - op2;
            ALU_SLT:  s_res = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
            ALU_SLTU: s_res = {{(XLEN-1){1'b0}}, op1 < op2};
            ALU_XOR:  s_res = op1 ^ op2;
            ALU_OR:   s_res = op1 | op2;
            ALU_AND:  s_res = op1 & op2;
            ALU_SLL:  s_res = op1 << op2[SHW-1:0];
            ALU_SRL:  s_res = op1 >> op2[SHW-1:0];
            ALU_SRA:  s_res = $signed(op1) >>> op2[SHW-1:0];
            ALU_LUI:  s_res = op2;
            ALU_JAL, ALU_JALR: begin
                s_res = op2 + XLEN'(4);
                s_br  = 1'b1;
            end
            ALU_BEQ:  s_br = op1 == op2;
            ALU_BNE:  s_br = op1 != op2;
            ALU_BLT:  s_br = $signed(op1) < $signed(op2);
            ALU_BGE:  s_br = $signed(op1) >= $signed(op2);
            ALU_BLTU: s_br = op1 < op2;
            ALU_BGEU: s_br = op1 >= op2;
            default: ;
        endcase
    end

    // Operand magnitudes and sign bookkeeping prepared at acceptance
    always_comb begin
        is_md    = alucode >= ALU_MUL && alucode <= ALU_REMU;
        is_div   = is_md && alucode[2];
        a_neg    = op1[XLEN-1] && (alucode == ALU_MULH || alucode == ALU_MULHSU ||
                                   alucode == ALU_DIV || alucode == ALU_REM);
        b_neg    = op2[XLEN-1] && (alucode == ALU_MULH || alucode == ALU_DIV || alucode == ALU_REM);
        a_mag    = a_neg ? -op1 : op1;
        b_mag    = b_neg ? -op2 : op2;
        div_zero = is_div && op2 == '0;
        div_ovf  = is_div && !alucode[0] && op1 == {1'b1, {(XLEN-1){1'b0}}} && op2 == '1;
        spec_res = div_zero ? (alucode[1] ? op1 : '1) : (alucode[1] ? '0 : op1);
    end

    // One radix-2 iteration: shift-add for multiply, restoring step for divide
    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_r2   = {hi_q, lo_q[XLEN-1]};
        div_diff = div_r2 - {1'b0, b_q};
        step_hi  = !op_q[2] ? mul_sum[XLEN:1] : (div_diff[XLEN] ? div_r2[XLEN-1:0] : div_diff[XLEN-1:0]);
        step_lo  = !op_q[2] ? {mul_sum[0], lo_q[XLEN-1:1]} : {lo_q[XLEN-2:0], !div_diff[XLEN]};
        prod     = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
        md_res   = !op_q[2] ? (op_q[1:0] == 2'd0 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]) :
                   op_q[1] ? (rneg_q ? -step_hi : step_hi) : (neg_q ? -step_lo : step_lo);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        br_d    = br_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        b_d     = b_q;
        op_d    = op_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        case (state_q)
            IDLE: if (in_valid) begin
                if (is_md && !div_zero && !div_ovf) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    hi_d    = '0;
                    lo_d    = a_mag;
                    b_d     = b_mag;
                    op_d    = alucode[2:0];
                    neg_d   = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                end else begin
                    state_d = DONE;
                    res_d   = is_md ? spec_res : s_res;
                    br_d    = !is_md && s_br;
                end
            end
            BUSY: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + SHW'(1);
                if (cnt_q == SHW'(XLEN-1)) begin
                    state_d = DONE;
                    res_d   = md_res;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            res_d   = res_q;
            br_d    = br_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            br_q    <= br_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            b_q     <= b_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
        end
    end

    assign in_ready   = state_q == IDLE;
    assign out_valid  = state_q == DONE;
    assign busy       = state_q == BUSY;
    assign alu_result = res_q;
    assign br_taken   = br_q;
endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-cycle, parametrised execute unit for the RV32I/RV32M core, replacing the purely combinational ALU in the execute stage. Single-cycle integer, branch and address operations complete in one cycle. Multiply and divide operations (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) run on an iterative radix-2 datapath. A valid/ready handshake on both sides lets the pipeline stall on long operations.

## Interface
Parameters:
- XLEN, 32, operand/result width; must be a power of two and at least 8.
- SHW, $clog2(XLEN), shift-amount width, taken from op2[SHW-1:0].

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- flush  in  1  synchronous abort of any in-flight or held operation.
- in_valid  in  1  operation presented.
- in_ready  out  1  unit can accept; equals (state == IDLE).
- alucode  in  6  operation code, from the `ALU_*` macros in define.vh; M-extension codes `ALU_MUL`..`ALU_REMU` are added there.
- op1  in  XLEN  operand 1 (rs1).
- op2  in  XLEN  operand 2 (rs2, immediate or PC per decoder).
- out_valid  out  1  result held valid.
- out_ready  in  1  consumer takes result.
- alu_result  out  XLEN  registered result.
- br_taken  out  1  registered branch/jump decision.
- busy  out  1  high in BUSY state.

## Operation
- States: IDLE, BUSY, DONE. Reset sets IDLE, out_valid=0, alu_result=0, br_taken=0, busy=0, iteration counter=0. in_ready therefore reads 1 out of reset.
- Acceptance: in IDLE with in_valid=1, sample alucode/op1/op2.
  - Single-cycle op: register result and br_taken, go to DONE.
  - Mul/div op: load operands, go to BUSY.
- Single-cycle results:
  - ADD and all load/store codes: op1+op2.
  - SUB: op1-op2.
  - SLT/SLTU: 1 or 0, signed/unsigned compare.
  - XOR/OR/AND: bitwise.
  - SLL/SRL/SRA: shift by op2[SHW-1:0]; SRA is arithmetic.
  - LUI: op2.
  - JAL/JALR: result op2+4, br_taken=1.
  - BEQ/BNE/BLT/BGE/BLTU/BGEU: result 0, br_taken = the comparison of op1 and op2 (signed for BLT/BGE, unsigned for BLTU/BGEU).
  - Unknown code: result 0, br_taken 0.
  - br_taken is 0 for every op not listed above.
- Multiply: shift-add on operand magnitudes, 2*XLEN-bit product.
  - MUL returns the low half.
  - MULH/MULHSU/MULHU return the high half.
  - Signs follow the RV32M rules: MULHSU treats op1 as signed and op2 as unsigned.
  - The product is negated when the result sign is negative, on the final iteration.
- Divide: restoring division on magnitudes.
  - Quotient sign is op1 XOR op2 (signed ops only).
  - Remainder sign follows op1.
- Divide special cases (resolved at acceptance, go directly to DONE, 1-cycle latency):
  - Divisor zero: DIV/DIVU give all ones; REM/REMU give op1.
  - Signed overflow (op1 = -2^(XLEN-1), op2 = -1): DIV gives op1; REM gives 0.
- BUSY: the counter runs XLEN iterations, one per cycle. The last iteration writes alu_result and moves to DONE.
- DONE: out_valid=1. alu_result and br_taken stay stable until out_ready=1, which returns the unit to IDLE. Input is not accepted in the same cycle as that handoff.
- flush: from any state, go to IDLE, clear out_valid, busy and the counter. flush wins over a simultaneous acceptance or handoff. alu_result is not cleared.
- Reset mid-operation: abandon immediately and take reset values.

## Timing
- Acceptance edge = edge where in_valid && in_ready.
- Single-cycle op and divide special cases: out_valid high after the acceptance edge (latency 1).
- Mul/div: busy high for XLEN cycles; out_valid high after edge XLEN+1 counted from acceptance (latency XLEN+1).
- Throughput: at most one operation per 2 cycles (accept, then hand off).
- out_valid never drops without out_ready, flush or reset.
- Inputs are ignored outside IDLE.

## Test plan
- Reset and single-cycle op: reset with rst_n=0 mid-run (all outputs 0, in_ready=1). Then ADD 0xFFFFFFFF+1 -> out_valid 1 cycle later, result 0x00000000, br_taken 0.
- Branch compare: BLT 0xFFFFFFFF vs 0x00000001 -> br_taken 1. BLTU with the same operands -> br_taken 0. JAL op2=0x100 -> result 0x104, br_taken 1.
- Multiply:
  - MULH 0x80000000 * 0x80000000 -> 0x40000000, out_valid at cycle 33, busy 32 cycles.
  - MUL 0xFFFFFFFF * 0xFFFFFFFF -> 0x00000001.
  - MULHU with the same operands -> 0xFFFFFFFE.
- Divide and special cases:
  - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
  - DIVU 5/0 -> 0xFFFFFFFF in 1 cycle.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
- Backpressure: hold out_ready=0 for 5 cycles after a result -> result stable, in_ready 0. Then raise out_ready -> IDLE the next cycle.
- Flush and async reset: flush at BUSY cycle 10 of a DIV -> IDLE next cycle, out_valid never asserted. Separately, drop rst_n asynchronously mid-BUSY -> outputs clear immediately, without waiting for a clock edge.
